seq_logic_unit: RTL and testbench
=================================

// Module: seq_logic_unit
//
// PURPOSE
//   Parametrised, multi-cycle bitwise logic unit; successor to the fixed 32-bit
//   AND array. Computes res = a OP b (AND/OR/XOR/NOR) one SLICE-bit slice per
//   clock, with valid/ready handshakes on input and output and a zero flag.
//   Sits beside the adder in the ALU datapath; trades latency for gate area.
//
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   SLICE  8   bits processed per cycle; WIDTH % SLICE must be 0, else elaboration error
//   (derived) NSLICE = WIDTH/SLICE, CW = max(1,$clog2(NSLICE)) counter width
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request (high only in IDLE)
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      res/zero valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   res        out  WIDTH  result
//   zero       out  1      1 when res == 0
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, cnt=0, res=0, zero=0, out_valid=0,
//     in_ready=1 after reset; latched a/b/op cleared to 0. Reset mid-RUN/DONE aborts; no output.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready edge: latch a,b,op; res<=0;
//     cnt<=0; nz<=0; go RUN. Inputs a/b/op are don't-care after acceptance.
//   - RUN: each cycle res[cnt*SLICE +: SLICE] <= OP(a_l slice, b_l slice);
//     nz <= nz | (|slice result); cnt<=cnt+1. When cnt==NSLICE-1 go DONE.
//     in_valid ignored (in_ready=0).
//   - DONE: out_valid=1, res held stable, zero = ~nz. On out_valid&&out_ready
//     go IDLE (in_ready=1 next cycle; no same-cycle accept).
//   - Latency: out_valid rises NSLICE clocks after the accepting edge.
//     Throughput: one op per NSLICE+2 cycles with out_ready held high.
//   - SLICE==WIDTH: RUN lasts exactly 1 cycle; cnt stays 0 (no wrap issue).
//   - res during RUN is partial and not meaningful; only sample with out_valid.
//   - out_ready while not DONE has no effect. NOR of upper slices yields 1s
//     per bit; no sign/width extension anywhere, results are purely bitwise.
//
// STRUCTURE
//   - Package alu_pkg: op encoding localparams (OP_AND..OP_NOR), FSM state
//     enum (IDLE/RUN/DONE).
//   - Sub-module logic_slice #(SLICE): combinational a_s OP b_s -> y_s, built
//     from per-bit gate primitives; instantiated once, fed by cnt-indexed mux.
//   - Top holds FSM, cnt, operand/result registers, nz accumulator.
//
// TESTING
//   1 AND a=FFFF0000 b=0F0F0F0F, out_ready=1 -> after 4 clks out_valid, res=0F0F0000, zero=0
//   2 XOR a=b=DEADBEEF -> res=00000000, zero=1; NOR a=b=0 -> res=FFFFFFFF, zero=0
//   3 Backpressure: out_ready=0 for 5 clks in DONE -> res/out_valid stable, in_ready=0; then 1-clk accept -> IDLE
//   4 in_valid with new a/b/op during RUN -> ignored; result matches first request
//   5 rst_n low mid-RUN (cnt=2) -> immediately IDLE, res=0, out_valid=0; next op correct
//   6 SLICE=32 and SLICE=1 builds: OR 80000001|00000010 -> 80000011 after 1 / 32 clks

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential logic unit: operation codes and FSM states.
package alu_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/logic_slice.sv
// One SLICE-bit bitwise AND/OR/XOR/NOR stage built from per-bit gate primitives.
// Purely combinational, zero latency; no flow control of its own.
module logic_slice
   import alu_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [1:0]       op,
   input  logic [SLICE-1:0] a_s,
   input  logic [SLICE-1:0] b_s,
   output logic [SLICE-1:0] y_s
);

   logic [SLICE-1:0] w_and;
   logic [SLICE-1:0] w_or;
   logic [SLICE-1:0] w_xor;
   logic [SLICE-1:0] w_nor;

   for (genvar i = 0; i < SLICE; i++) begin : g_bit
      and u_and (w_and[i], a_s[i], b_s[i]);
      or  u_or  (w_or[i],  a_s[i], b_s[i]);
      xor u_xor (w_xor[i], a_s[i], b_s[i]);
      nor u_nor (w_nor[i], a_s[i], b_s[i]);
   end

   always_comb begin
      y_s = w_and;
      case (op)
         OP_AND:  y_s = w_and;
         OP_OR:   y_s = w_or;
         OP_XOR:  y_s = w_xor;
         OP_NOR:  y_s = w_nor;
         default: y_s = w_and;
      endcase
   end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: res = a OP b, one SLICE per clock; out_valid NSLICE clocks after accept.
// in_ready only in IDLE; result held in DONE until out_ready, so a stalled consumer blocks new requests.
module seq_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
   end

   state_e           r_state;
   state_e           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_nz;

   logic             w_accept;
   logic             w_last;
   logic [SLICE-1:0] w_a_s;
   logic [SLICE-1:0] w_b_s;
   logic [SLICE-1:0] w_y_s;

   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == CW'(NSLICE - 1));
   assign w_a_s    = r_a[int'(r_cnt) * SLICE +: SLICE];
   assign w_b_s    = r_b[int'(r_cnt) * SLICE +: SLICE];

   logic_slice #(.SLICE(SLICE)) u_slice (
      .op  (r_op),
      .a_s (w_a_s),
      .b_s (w_b_s),
      .y_s (w_y_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      zero      = (r_state == DONE) && !r_nz;
   end

   // Counter holds on the last slice so SLICE==WIDTH never steps past slice 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= OP_AND;
         r_res <= '0;
         r_cnt <= '0;
         r_nz  <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_op  <= op;
         r_res <= '0;
         r_cnt <= '0;
         r_nz  <= 1'b0;
      end else if (r_state == RUN) begin
         r_res[int'(r_cnt) * SLICE +: SLICE] <= w_y_s;
         r_nz <= r_nz || (|w_y_s);
         if (!w_last) r_cnt <= r_cnt + CW'(1);
      end
   end

   assign res = r_res;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed bench for seq_logic_unit: SLICE=8 main build plus SLICE=32 and SLICE=1 builds.
module tb_seq_logic_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv  [3];
   logic        ir  [3];
   logic        ov  [3];
   logic        orr [3];
   logic        zr  [3];
   logic [1:0]  opv [3];
   logic [31:0] av  [3];
   logic [31:0] bv  [3];
   logic [31:0] rv  [3];

   int n_checks = 0;
   int n_errors = 0;
   int lat;

   always #5 clk = ~clk;

   seq_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
      .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(orr[0]), .res(rv[0]), .zero(zr[0])
   );

   seq_logic_unit #(.WIDTH(32), .SLICE(32)) dut_s32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
      .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(orr[1]), .res(rv[1]), .zero(zr[1])
   );

   seq_logic_unit #(.WIDTH(32), .SLICE(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op(opv[2]),
      .a(av[2]), .b(bv[2]), .out_valid(ov[2]), .out_ready(orr[2]), .res(rv[2]), .zero(zr[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request on unit s and wait (bounded) for out_valid; lat counts clocks after accept.
   task automatic run_op(input int s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int latency);
      @(negedge clk);
      check("accept_ready", 32'(ir[s]), 32'd1);
      opv[s] = op;
      av[s]  = a;
      bv[s]  = b;
      iv[s]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[s]  = 1'b0;
      opv[s] = ~op;
      av[s]  = ~a;
      bv[s]  = 32'h5555_AAAA;
      latency = 0;
      while (!ov[s] && latency < 200) begin
         if (inject && latency == 1) begin
            iv[s]  = 1'b1;
            opv[s] = OP_AND;
            av[s]  = 32'hFFFF_FFFF;
            bv[s]  = 32'hFFFF_FFFF;
            #1 check("run_in_ready", 32'(ir[s]), 32'd0);
         end
         @(negedge clk);
         latency++;
      end
      iv[s] = 1'b0;
      if (!ov[s]) check("out_valid_timeout", 32'(ov[s]), 32'd1);
   endtask

   // Consumer accepts with out_ready already high; unit must be back in IDLE next cycle.
   task automatic finish_op(input int s);
      orr[s] = 1'b1;
      @(negedge clk);
      check("post_ovalid", 32'(ov[s]), 32'd0);
      check("post_iready", 32'(ir[s]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; orr[i] = 1'b0; opv[i] = 2'b00; av[i] = '0; bv[i] = '0;
      end
      #12;
      check("rst_iready", 32'(ir[0]), 32'd1);
      check("rst_ovalid", 32'(ov[0]), 32'd0);
      check("rst_res",    rv[0],      32'd0);
      check("rst_zero",   32'(zr[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      orr[0] = 1'b1;
      run_op(0, OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, lat);
      check("and_lat",  32'(lat),   32'd4);
      check("and_res",  rv[0],      32'h0F0F_0000);
      check("and_zero", 32'(zr[0]), 32'd0);
      finish_op(0);

      run_op(0, OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, lat);
      check("xor_res",  rv[0],      32'h0000_0000);
      check("xor_zero", 32'(zr[0]), 32'd1);
      finish_op(0);

      run_op(0, OP_NOR, 32'h0, 32'h0, 1'b0, lat);
      check("nor_res",  rv[0],      32'hFFFF_FFFF);
      check("nor_zero", 32'(zr[0]), 32'd0);
      finish_op(0);

      orr[0] = 1'b0;
      run_op(0, OP_OR, 32'h8000_0001, 32'h0000_0010, 1'b0, lat);
      check("bp_lat", 32'(lat), 32'd4);
      for (int k = 0; k < 5; k++) begin
         check("bp_ovalid", 32'(ov[0]), 32'd1);
         check("bp_res",    rv[0],      32'h8000_0011);
         check("bp_iready", 32'(ir[0]), 32'd0);
         @(negedge clk);
      end
      finish_op(0);

      run_op(0, OP_OR, 32'h1234_5678, 32'h8765_4321, 1'b1, lat);
      check("inj_lat",  32'(lat),   32'd4);
      check("inj_res",  rv[0],      32'h9775_5779);
      check("inj_zero", 32'(zr[0]), 32'd0);
      finish_op(0);

      // Abort a request with cnt==2 by asserting reset between edges.
      @(negedge clk);
      opv[0] = OP_XOR; av[0] = 32'hA5A5_A5A5; bv[0] = 32'h0F0F_0F0F; iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_ovalid", 32'(ov[0]), 32'd0);
      check("abort_iready", 32'(ir[0]), 32'd1);
      check("abort_res",    rv[0],      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_no_out", 32'(ov[0]), 32'd0);
      run_op(0, OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, lat);
      check("after_abort_lat", 32'(lat), 32'd4);
      check("after_abort_res", rv[0],    32'hAAAA_AAAA);
      finish_op(0);

      orr[1] = 1'b1;
      run_op(1, OP_OR, 32'h8000_0001, 32'h0000_0010, 1'b0, lat);
      check("s32_lat", 32'(lat), 32'd1);
      check("s32_res", rv[1],    32'h8000_0011);
      finish_op(1);

      orr[2] = 1'b1;
      run_op(2, OP_OR, 32'h8000_0001, 32'h0000_0010, 1'b0, lat);
      check("s1_lat",  32'(lat),   32'd32);
      check("s1_res",  rv[2],      32'h8000_0011);
      check("s1_zero", 32'(zr[2]), 32'd0);
      finish_op(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
